// File: rtl/eth_rx_filter_pkg.sv
// Shared constants and types for the Ethernet RX frame filter.
package eth_rx_filter_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [47:0] MAC_BCAST      = 48'hffff_ffff_ffff;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_t;

  function automatic logic type_ok(input logic [15:0] eth_type);
    return (eth_type == ETHERTYPE_IPV4) || (eth_type == ETHERTYPE_ARP);
  endfunction

endpackage

// File: rtl/eth_rx_filter_if.sv
// Ethernet header plus byte-wide payload stream, as produced by the header/payload splitter.
interface eth_rx_filter_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  hdr_valid;
  logic                  hdr_ready;
  logic [47:0]           dest_mac;
  logic [47:0]           src_mac;
  logic [15:0]           eth_type;
  logic                  is_arp;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output hdr_valid, dest_mac, src_mac, eth_type, is_arp,
    output tdata, tvalid, tlast, tuser,
    input  hdr_ready, tready
  );

  // The upstream splitter has no ARP flag, so the receiving side does not see one.
  modport slave (
    input  hdr_valid, dest_mac, src_mac, eth_type,
    input  tdata, tvalid, tlast, tuser,
    output hdr_ready, tready
  );

endinterface

// File: rtl/eth_rx_filter_axis_out_reg.sv
// Two-entry skid register: full throughput, upstream ready is registered so the
// downstream ready never reaches it combinationally.
module axis_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  up_last,
  input  logic                  up_user,
  input  logic                  up_valid,
  output logic                  up_ready,
  output logic [DATA_WIDTH-1:0] dn_data,
  output logic                  dn_last,
  output logic                  dn_user,
  output logic                  dn_valid,
  input  logic                  dn_ready
);

  logic [DATA_WIDTH-1:0] data_p0, data_p1;
  logic                  last_p0, last_p1;
  logic                  user_p0, user_p1;
  logic                  vld_p0, vld_p1;
  logic                  vld_p0_next, vld_p1_next;
  logic                  ready_reg, ready_early;
  logic                  load_p0_up, load_p1_up, load_p0_tmp;

  // ready_reg=1 implies the temp slot is empty, so an accepted beat always has a home.
  always_comb begin
    ready_early = dn_ready || (!vld_p1 && (!vld_p0 || !up_valid));
    vld_p0_next = vld_p0;
    vld_p1_next = vld_p1;
    load_p0_up  = 1'b0;
    load_p1_up  = 1'b0;
    load_p0_tmp = 1'b0;
    if (ready_reg) begin
      if (dn_ready || !vld_p0) begin
        vld_p0_next = up_valid;
        load_p0_up  = 1'b1;
      end else begin
        vld_p1_next = up_valid;
        load_p1_up  = 1'b1;
      end
    end else if (dn_ready) begin
      vld_p0_next = vld_p1;
      vld_p1_next = 1'b0;
      load_p0_tmp = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      vld_p0    <= vld_p0_next;
      vld_p1    <= vld_p1_next;
      ready_reg <= ready_early;
    end
  end

  // p0: output stage, p1: temp (skid) stage
  always_ff @(posedge clk) begin
    if (load_p0_up) begin
      data_p0 <= up_data;
      last_p0 <= up_last;
      user_p0 <= up_user;
    end else if (load_p0_tmp) begin
      data_p0 <= data_p1;
      last_p0 <= last_p1;
      user_p0 <= user_p1;
    end
    if (load_p1_up) begin
      data_p1 <= up_data;
      last_p1 <= up_last;
      user_p1 <= up_user;
    end
  end

  assign up_ready = ready_reg;
  assign dn_data  = data_p0;
  assign dn_last  = last_p0;
  assign dn_user  = user_p0;
  assign dn_valid = vld_p0;

endmodule

// File: rtl/eth_rx_filter.sv
// Drops frames not addressed to this station (or broadcast) or not IPv4/ARP;
// forwards accepted headers and payload unchanged and counts the drops.
module eth_rx_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter bit BROADCAST_EN = 1'b1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [47:0]          local_mac,
  eth_rx_filter_if.slave       s_eth,
  eth_rx_filter_if.master      m_eth,
  output logic                 frame_dropped,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic                 busy
);

  state_t      state, state_next;
  logic        hdr_hs, match, accept;
  logic        beat_hs, last_hs, fwd_beat;
  logic        out_ready;
  logic        hdr_vld_p0;
  logic [47:0] dest_p0, src_p0;
  logic [15:0] type_p0;
  logic        arp_p0;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign match   = (s_eth.dest_mac == local_mac) ||
                   (BROADCAST_EN && (s_eth.dest_mac == MAC_BCAST));
  assign accept  = match && type_ok(s_eth.eth_type);
  assign hdr_hs  = s_eth.hdr_valid && s_eth.hdr_ready;
  assign beat_hs = s_eth.tvalid && s_eth.tready;
  assign last_hs = beat_hs && s_eth.tlast;
  assign fwd_beat = beat_hs && (state == FWD);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Header ready is held low during reset so nothing is taken before the FSM is clean.
  always_comb begin
    state_next      = state;
    s_eth.hdr_ready = 1'b0;
    s_eth.tready    = 1'b0;
    busy            = (state != IDLE);
    unique case (state)
      IDLE: begin
        s_eth.hdr_ready = rst_n && (!hdr_vld_p0 || m_eth.hdr_ready);
        if (hdr_hs) state_next = accept ? FWD : DROP;
      end
      FWD: begin
        s_eth.tready = out_ready;
        if (last_hs) state_next = IDLE;
      end
      DROP: begin
        s_eth.tready = 1'b1;
        if (last_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // p0: registered output header, independent of the payload stream
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_vld_p0    <= 1'b0;
      dest_p0       <= '0;
      src_p0        <= '0;
      type_p0       <= '0;
      arp_p0        <= 1'b0;
      frame_dropped <= 1'b0;
      drop_count    <= '0;
    end else begin
      frame_dropped <= 1'b0;
      if (m_eth.hdr_ready) hdr_vld_p0 <= 1'b0;
      if (hdr_hs) begin
        if (accept) begin
          hdr_vld_p0 <= 1'b1;
          dest_p0    <= s_eth.dest_mac;
          src_p0     <= s_eth.src_mac;
          type_p0    <= s_eth.eth_type;
          arp_p0     <= (s_eth.eth_type == ETHERTYPE_ARP);
        end else begin
          frame_dropped <= 1'b1;
          drop_count    <= sat_inc(drop_count);
        end
      end
    end
  end

  assign m_eth.hdr_valid = hdr_vld_p0;
  assign m_eth.dest_mac  = dest_p0;
  assign m_eth.src_mac   = src_p0;
  assign m_eth.eth_type  = type_p0;
  assign m_eth.is_arp    = arp_p0;

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_data  (s_eth.tdata),
    .up_last  (s_eth.tlast),
    .up_user  (s_eth.tuser),
    .up_valid (fwd_beat),
    .up_ready (out_ready),
    .dn_data  (m_eth.tdata),
    .dn_last  (m_eth.tlast),
    .dn_user  (m_eth.tuser),
    .dn_valid (m_eth.tvalid),
    .dn_ready (m_eth.tready)
  );

endmodule
